keccak_round_seq: RTL
=====================

# keccak_round_seq

Round sequencer for the low-throughput Keccak-f[1600] permutation core. It generates the one-hot round-index vector that the combinational round-constant table consumes. It steps through the rounds under a per-round advance handshake from the permutation datapath and signals completion. An optional LFSR engine produces the 64-bit round constant sequentially, so the table can be bypassed or cross-checked.

## Interface
- NROUNDS, 24, number of rounds and width of the one-hot index; legal range 2..24.
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous assert, active-low; releases synchronously to clk externally.
- start  in  1  begin a permutation; sampled only while idle.
- adv  in  1  datapath has consumed the current round; sampled only while busy.
- i  out  NROUNDS  one-hot round index; bit k = round k; all-zero when idle.
- round_idx  out  5  binary round number, equal to log2(i); 0 when idle.
- busy  out  1  permutation in progress.
- last  out  1  equals i[NROUNDS-1].
- done  out  1  single-cycle pulse after the final round is consumed.
- rc  out  64  round constant for the current round; present only with KECCAK_RC_LFSR_EN.

## Operation
- Two states: IDLE (busy=0) and RUN (busy=1). All outputs are registered.
- IDLE with start=1: go to RUN next cycle, with i=1, round_idx=0, done=0.
- RUN with adv=0: hold i, round_idx, and rc.
- RUN with adv=1 and last=0: i shifts left by one and round_idx increments.
- RUN with adv=1 and last=1: go to IDLE. Next cycle i=0, round_idx=0, busy=0, done=1.
- done is high for exactly one cycle; otherwise done=0.
- start while busy is ignored; there is no queueing. adv while idle is ignored.
- start in the same cycle that done=1 is accepted, because the block is idle then.
- Exactly one bit of i is set in RUN and none in IDLE.
- Reset mid-run aborts immediately: all outputs go to 0, state goes to IDLE, and no done pulse is produced.

## Timing
- Reset values: i=0, round_idx=0, busy=0, last=0, done=0, rc=0.
- Latency from start to first round is 1 cycle: start sampled at edge t gives i=1 after edge t.
- Each adv high at an edge advances one round after that edge; a back-to-back run takes NROUNDS cycles of busy.
- With start at t and adv held high: busy for cycles t+1..t+NROUNDS, done at t+NROUNDS+1.
- last is a combinational copy of the registered i[NROUNDS-1], so it has no extra delay.

## Configuration
- KECCAK_RC_LFSR_EN defined:
  - Adds port rc and an 8-bit LFSR s with reset value 8'h01.
  - One LFSR step: out=s[0]; fb=s[7]; s={s[6:0],1'b0}; then s[0]^=fb, s[4]^=fb, s[5]^=fb, s[6]^=fb.
  - Each round consumes 7 steps, unrolled combinationally. The output of step j sets rc[2^j-1] for j=0..6; all other rc bits are 0.
  - On start, s reloads 8'h01 and rc loads round 0's constant, advancing s by 7 steps.
  - On each adv that is not the final round, rc loads the next round's constant.
  - In IDLE, rc=0.
- KECCAK_RC_LFSR_EN undefined: no rc port and no LFSR logic; the downstream table decodes i.

## Test plan
- Reset, then start, with adv tied high: i walks 0x000001 → 0x800000 over 24 cycles, round_idx 0→23, last high only in the final round, done=1 exactly at t+25, then all outputs return to 0.
- adv toggled 1,0,0,1 during RUN: i changes only after the cycles with adv=1, and round_idx tracks i throughout.
- start pulsed again at round 5: ignored, run length unchanged. start asserted in the done cycle: new run begins with i=1 on the next cycle.
- reset_n dropped asynchronously at round 10 (mid-cycle): outputs clear immediately without waiting for clk, and no done pulse is produced after release.
- With the macro defined: rc is 0x0000000000000001 at round 0, 0x0000000000008082 at round 1, 0x800000000000808A at round 2, and 0x8000000080008008 at round 23. rc matches the table output for all 24 rounds.
- NROUNDS=2 build: two-cycle run, last high at i=2'b10, done at t+3.

Source files
------------

// File: rtl/keccak_round_seq.sv
// rtl/keccak_round_seq.sv - Keccak-f[1600] round sequencer; optional LFSR round constant under KECCAK_RC_LFSR_EN
module keccak_round_seq #(
    parameter int NROUNDS = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               adv,
    output logic [NROUNDS-1:0] i,
    output logic [4:0]         round_idx,
    output logic               busy,
    output logic               last,
    output logic               done
`ifdef KECCAK_RC_LFSR_EN
    ,
    output logic [63:0]        rc
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NROUNDS-1:0] i_q, i_d;
    logic [4:0]         round_q, round_d;
    logic               done_q, done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                i_d     = '0;
                round_d = '0;
                if (start) begin
                    state_d = RUN;
                    i_d[0]  = 1'b1;
                end
            end
            RUN: begin
                if (adv) begin
                    if (i_q[NROUNDS-1]) begin
                        state_d = IDLE;
                        i_d     = '0;
                        round_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        i_d     = i_q << 1;
                        round_d = round_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                i_d     = '0;
                round_d = '0;
            end
        endcase
    end

    assign i         = i_q;
    assign round_idx = round_q;
    assign busy      = (state_q == RUN);
    assign last      = i_q[NROUNDS-1];
    assign done      = done_q;

`ifdef KECCAK_RC_LFSR_EN
    // Seven LFSR steps per round; step j drives rc bit 2^j-1. Returns {next_state, rc}.
    function automatic logic [71:0] rc_round(input logic [7:0] s_in);
        logic [7:0]  s;
        logic [63:0] r;
        logic        fb;
        s = s_in;
        r = '0;
        for (int j = 0; j < 7; j++) begin
            r[(1 << j) - 1] = s[0];
            fb   = s[7];
            s    = {s[6:0], 1'b0};
            s[0] = s[0] ^ fb;
            s[4] = s[4] ^ fb;
            s[5] = s[5] ^ fb;
            s[6] = s[6] ^ fb;
        end
        return {s, r};
    endfunction

    logic [7:0]  lfsr_q, lfsr_d;
    logic [63:0] rc_q, rc_d;
    logic [71:0] from_seed, from_cur;

    assign from_seed = rc_round(8'h01);
    assign from_cur  = rc_round(lfsr_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 8'h01;
            rc_q   <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            rc_q   <= rc_d;
        end
    end

    always_comb begin
        lfsr_d = lfsr_q;
        rc_d   = rc_q;
        case (state_q)
            IDLE: begin
                rc_d = '0;
                if (start) begin
                    lfsr_d = from_seed[71:64];
                    rc_d   = from_seed[63:0];
                end
            end
            RUN: begin
                if (adv) begin
                    if (i_q[NROUNDS-1]) begin
                        rc_d = '0;
                    end else begin
                        lfsr_d = from_cur[71:64];
                        rc_d   = from_cur[63:0];
                    end
                end
            end
            default: rc_d = '0;
        endcase
    end

    assign rc = rc_q;
`endif

endmodule
